// File: rtl/mips16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips16_pkg
// Description : Shared widths, constants and forwarding-select encoding for
//               the mips16 operand fetch stage.
// Revision    : 1.0
// ============================================================================
package mips16_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 6;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_EX   = 3'd1,
        FWD_MEM  = 3'd2,
        FWD_WB   = 3'd3,
        FWD_RF   = 3'd4
    } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Resolves one source operand: register zero, then the newest
//               in-flight producer (EX, MEM, WB), else regfile read data.
// Revision    : 1.0
// ============================================================================
module fwd_mux
    import mips16_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic [AW-1:0] i_src,
    input  logic          i_ex_fwd,
    input  logic [AW-1:0] i_ex_waddr,
    input  logic [DW-1:0] i_ex_wdata,
    input  logic          i_mem_wen,
    input  logic [AW-1:0] i_mem_waddr,
    input  logic [DW-1:0] i_mem_wdata,
    input  logic          i_wb_wen,
    input  logic [AW-1:0] i_wb_waddr,
    input  logic [DW-1:0] i_wb_wdata,
    input  logic [DW-1:0] i_rf_data,
    output logic [DW-1:0] o_data
);

    fwd_sel_t w_sel;

    always_comb begin
        w_sel = FWD_RF;
        if (i_src == REG_ZERO[AW-1:0])
            w_sel = FWD_ZERO;
        else if (i_ex_fwd && (i_ex_waddr == i_src))
            w_sel = FWD_EX;
        else if (i_mem_wen && (i_mem_waddr == i_src))
            w_sel = FWD_MEM;
        // The regfile commits WB data only at the clock edge, so bypass it here.
        else if (i_wb_wen && (i_wb_waddr == i_src))
            w_sel = FWD_WB;
    end

    always_comb begin
        o_data = i_rf_data;
        case (w_sel)
            FWD_ZERO: o_data = '0;
            FWD_EX:   o_data = i_ex_wdata;
            FWD_MEM:  o_data = i_mem_wdata;
            FWD_WB:   o_data = i_wb_wdata;
            default:  o_data = i_rf_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage
// Description : ID->EX stage: regfile addressing, RAW forwarding, load-use
//               stall and the ID/EX pipeline register.
// Revision    : 1.0
// ============================================================================
module operand_fetch_stage
    import mips16_pkg::*;
(
    input  logic              clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic              in_use_rt,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_wen,
    input  logic              in_load,
    input  logic [OP_W-1:0]   in_op,
    output logic [ADDR_W-1:0] rf_aaddr,
    output logic [ADDR_W-1:0] rf_baddr,
    input  logic [DATA_W-1:0] rf_adata,
    input  logic [DATA_W-1:0] rf_bdata,
    input  logic              ex_valid,
    input  logic              ex_wen,
    input  logic              ex_load,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              wb_wen,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wen,
    output logic              out_load,
    output logic [OP_W-1:0]   out_op
);

    logic              w_ex_fwd;
    logic              w_hazard;
    logic              w_advance;
    logic [DATA_W-1:0] w_a_res;
    logic [DATA_W-1:0] w_b_res;

    logic              r_valid_q, w_valid_d;
    logic [DATA_W-1:0] r_a_q,     w_a_d;
    logic [DATA_W-1:0] r_b_q,     w_b_d;
    logic [ADDR_W-1:0] r_rd_q,    w_rd_d;
    logic              r_wen_q,   w_wen_d;
    logic              r_load_q,  w_load_d;
    logic [OP_W-1:0]   r_op_q,    w_op_d;

    assign rf_aaddr = in_rs;
    assign rf_baddr = in_rt;

    // A load in EX has no data yet; only ALU results are forwardable from EX.
    assign w_ex_fwd = ex_valid & ex_wen & ~ex_load;

    fwd_mux u_fwd_a (
        .i_src       (in_rs),
        .i_ex_fwd    (w_ex_fwd),
        .i_ex_waddr  (ex_waddr),
        .i_ex_wdata  (ex_wdata),
        .i_mem_wen   (mem_wen),
        .i_mem_waddr (mem_waddr),
        .i_mem_wdata (mem_wdata),
        .i_wb_wen    (wb_wen),
        .i_wb_waddr  (wb_waddr),
        .i_wb_wdata  (wb_wdata),
        .i_rf_data   (rf_adata),
        .o_data      (w_a_res)
    );

    fwd_mux u_fwd_b (
        .i_src       (in_rt),
        .i_ex_fwd    (w_ex_fwd),
        .i_ex_waddr  (ex_waddr),
        .i_ex_wdata  (ex_wdata),
        .i_mem_wen   (mem_wen),
        .i_mem_waddr (mem_waddr),
        .i_mem_wdata (mem_wdata),
        .i_wb_wen    (wb_wen),
        .i_wb_waddr  (wb_waddr),
        .i_wb_wdata  (wb_wdata),
        .i_rf_data   (rf_bdata),
        .o_data      (w_b_res)
    );

    always_comb begin
        w_hazard  = in_valid & ex_valid & ex_wen & ex_load & (ex_waddr != REG_ZERO) &
                    ((ex_waddr == in_rs) | (in_use_rt & (ex_waddr == in_rt)));
        w_advance = out_ready | ~r_valid_q;
        in_ready  = w_advance & ~w_hazard;

        w_valid_d = r_valid_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_rd_d    = r_rd_q;
        w_wen_d   = r_wen_q;
        w_load_d  = r_load_q;
        w_op_d    = r_op_q;

        if (w_advance) begin
            w_valid_d = in_valid & ~w_hazard & ~flush;
            w_a_d     = w_a_res;
            w_b_d     = in_use_rt ? w_b_res : in_imm;
            w_rd_d    = in_rd;
            w_op_d    = in_op;
            // Bubbles must never write back or look like a load downstream.
            w_wen_d   = w_valid_d & in_wen;
            w_load_d  = w_valid_d & in_load;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_valid_q <= 1'b0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_rd_q    <= '0;
            r_wen_q   <= 1'b0;
            r_load_q  <= 1'b0;
            r_op_q    <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_rd_q    <= w_rd_d;
            r_wen_q   <= w_wen_d;
            r_load_q  <= w_load_d;
            r_op_q    <= w_op_d;
        end
    end

    assign out_valid = r_valid_q;
    assign out_a     = r_a_q;
    assign out_b     = r_b_q;
    assign out_rd    = r_rd_q;
    assign out_wen   = r_wen_q;
    assign out_load  = r_load_q;
    assign out_op    = r_op_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch_stage
// Description : Self-checking bench: directed vectors, a register-file model
//               and a "latest value of each register" reference.
// Revision    : 1.0
// ============================================================================
module tb_operand_fetch_stage;
    import mips16_pkg::*;

    logic              clk = 1'b0;
    logic              Reset = 1'b1;
    logic              in_valid = 1'b0, in_use_rt = 1'b0, in_wen = 1'b0, in_load = 1'b0;
    logic [ADDR_W-1:0] in_rs = '0, in_rt = '0, in_rd = '0;
    logic [DATA_W-1:0] in_imm = '0;
    logic [OP_W-1:0]   in_op = '0;
    logic              ex_valid = 1'b0, ex_wen = 1'b0, ex_load = 1'b0;
    logic [ADDR_W-1:0] ex_waddr = '0, mem_waddr = '0, wb_waddr = '0;
    logic [DATA_W-1:0] ex_wdata = '0, mem_wdata = '0, wb_wdata = '0;
    logic              mem_wen = 1'b0, wb_wen = 1'b0, flush = 1'b0, out_ready = 1'b1;

    logic              in_ready, out_valid, out_wen, out_load;
    logic [ADDR_W-1:0] rf_aaddr, rf_baddr, out_rd;
    logic [DATA_W-1:0] rf_adata, rf_bdata, out_a, out_b;
    logic [OP_W-1:0]   out_op;

    logic [DATA_W-1:0] regs [32];
    assign rf_adata = regs[rf_aaddr];
    assign rf_bdata = regs[rf_baddr];

    operand_fetch_stage dut (
        .clk(clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs), .in_rt(in_rt),
        .in_use_rt(in_use_rt), .in_imm(in_imm), .in_rd(in_rd), .in_wen(in_wen),
        .in_load(in_load), .in_op(in_op),
        .rf_aaddr(rf_aaddr), .rf_baddr(rf_baddr), .rf_adata(rf_adata), .rf_bdata(rf_bdata),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_load(ex_load), .ex_waddr(ex_waddr),
        .ex_wdata(ex_wdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wen(out_wen),
        .out_load(out_load), .out_op(out_op)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the value an instruction must see is the newest one that
    // will be written to that register, r0 being hardwired to zero.
    function automatic logic [DATA_W-1:0] latest(input logic [ADDR_W-1:0] r);
        if (r == 0)                                        return '0;
        if (ex_valid && ex_wen && !ex_load && ex_waddr == r) return ex_wdata;
        if (mem_wen && mem_waddr == r)                     return mem_wdata;
        if (wb_wen && wb_waddr == r)                       return wb_wdata;
        return regs[r];
    endfunction

    // A load still in EX has not produced its value: any reader must wait.
    function automatic logic must_wait();
        return in_valid && ex_valid && ex_wen && ex_load && ex_waddr != 0 &&
               (ex_waddr == in_rs || (in_use_rt && ex_waddr == in_rt));
    endfunction

    logic              m_valid = 1'b0, m_wen = 1'b0, m_load = 1'b0;
    logic [DATA_W-1:0] m_a = '0, m_b = '0;
    logic [ADDR_W-1:0] m_rd = '0;
    logic [OP_W-1:0]   m_op = '0;

    always @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 16'h4441 + DATA_W'(i);
            m_valid <= 1'b0; m_wen <= 1'b0; m_load <= 1'b0;
            m_a <= '0; m_b <= '0; m_rd <= '0; m_op <= '0;
        end else begin
            if (wb_wen) regs[wb_waddr] <= wb_wdata;
            if (out_ready || !m_valid) begin
                if (flush || !in_valid || must_wait()) begin
                    m_valid <= 1'b0; m_wen <= 1'b0; m_load <= 1'b0;
                end else begin
                    m_valid <= 1'b1; m_wen <= in_wen; m_load <= in_load;
                    m_a  <= latest(in_rs);
                    m_b  <= in_use_rt ? latest(in_rt) : in_imm;
                    m_rd <= in_rd; m_op <= in_op;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_wen",   32'(out_wen),   32'(m_wen));
        check("out_load",  32'(out_load),  32'(m_load));
        check("in_ready",  32'(in_ready),  32'((out_ready || !m_valid) && !must_wait()));
        check("rf_aaddr",  32'(rf_aaddr),  32'(in_rs));
        check("rf_baddr",  32'(rf_baddr),  32'(in_rt));
        if (m_valid) begin
            check("out_a",  32'(out_a),  32'(m_a));
            check("out_b",  32'(out_b),  32'(m_b));
            check("out_rd", 32'(out_rd), 32'(m_rd));
            check("out_op", 32'(out_op), 32'(m_op));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset with a valid instruction present
        in_valid = 1'b1; in_rs = 5'd3; in_rd = 5'd9; in_wen = 1'b1; in_op = 6'h2A;
        tick(3);
        check("lit_reset_valid", 32'(out_valid), 32'h0);
        check("lit_reset_a",     32'(out_a),     32'h0);
        Reset = 1'b0; in_valid = 1'b0;
        #1;
        check("lit_ready_after_reset", 32'(in_ready), 32'h1);
        tick();

        // Forwarding priority on rs=3
        in_valid = 1'b1; in_rs = 5'd3; in_use_rt = 1'b0; in_imm = 16'h0007;
        ex_valid = 1'b1; ex_wen = 1'b1; ex_load = 1'b0; ex_waddr = 5'd3; ex_wdata = 16'h1111;
        mem_wen = 1'b1; mem_waddr = 5'd3; mem_wdata = 16'h2222;
        wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 16'h3333;
        tick();
        check("lit_prio_ex", 32'(out_a), 32'h1111);
        check("lit_imm_b",   32'(out_b), 32'h0007);
        ex_valid = 1'b0;
        tick();
        check("lit_prio_mem", 32'(out_a), 32'h2222);
        mem_wen = 1'b0;
        tick();
        check("lit_prio_wb", 32'(out_a), 32'h3333);
        wb_wen = 1'b0; in_rs = 5'd4;
        tick();
        check("lit_rf", 32'(out_a), 32'h4445);

        // Register zero never forwards
        in_rs = 5'd0; ex_valid = 1'b1; ex_wen = 1'b1; ex_waddr = 5'd0; ex_wdata = 16'hBEEF;
        tick();
        check("lit_zero", 32'(out_a), 32'h0);

        // Load-use on rt=5
        in_rs = 5'd1; in_rt = 5'd5; in_use_rt = 1'b1;
        ex_load = 1'b1; ex_waddr = 5'd5; ex_wdata = 16'hDEAD;
        #1;
        check("lit_lu_stall", 32'(in_ready), 32'h0);
        tick();
        check("lit_lu_bubble", 32'(out_valid), 32'h0);
        ex_valid = 1'b0; ex_load = 1'b0;
        mem_wen = 1'b1; mem_waddr = 5'd5; mem_wdata = 16'h00A5;
        #1;
        check("lit_lu_release", 32'(in_ready), 32'h1);
        tick();
        check("lit_lu_valid", 32'(out_valid), 32'h1);
        check("lit_lu_fwd",   32'(out_b),     32'h00A5);
        mem_wen = 1'b0;

        // Backpressure
        in_rs = 5'd2; in_use_rt = 1'b0;
        tick();
        out_ready = 1'b0; in_rs = 5'd6; in_op = 6'h15;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit_bp_ready", 32'(in_ready), 32'h0);
            check("lit_bp_hold",  32'(out_a),    32'h4443);
        end
        out_ready = 1'b1;
        tick();
        check("lit_bp_next", 32'(out_a), 32'h4447);

        // Flush on the stall cycle
        in_rs = 5'd7; ex_valid = 1'b1; ex_wen = 1'b1; ex_load = 1'b1; ex_waddr = 5'd7;
        flush = 1'b1;
        tick();
        check("lit_flush_bubble", 32'(out_valid), 32'h0);
        flush = 1'b0; ex_valid = 1'b0; ex_load = 1'b0;
        mem_wen = 1'b1; mem_waddr = 5'd7; mem_wdata = 16'h0777;
        #1;
        check("lit_flush_clear", 32'(in_ready), 32'h1);
        tick();
        check("lit_flush_next", 32'(out_a), 32'h0777);

        mem_wen = 1'b0; in_valid = 1'b0;
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
